dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the shared data memory (DMEM).
- Requester M0 is the CPU load/store stage; requester M1 is the testbench/DMA loader port.
- Grants one access per cycle using round-robin and drives the DMEM address, data, write and read lines from registered values.
- Captures combinational DMEM read data into a per-requester response register.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arbiter_rr_pick2.sv | 23 ++
 rtl/dmem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam int unsigned DMEM_ADDR_W_DEFAULT = 32;
  localparam int unsigned DMEM_DATA_W_DEFAULT = 32;
  localparam int unsigned DMEM_DEPTH_DEFAULT  = 256;

  // One-hot requester mask for a given owner.
  function automatic logic [1:0] owner_mask(owner_e o);
    return (o == OWN_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Pure combinational two-way round-robin picker.
// A single requester always wins; with both requesting, the one that did
// not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  // Select winner from the request pair and the previous winner.
  always_comb begin
    valid_o  = |req_i;
    winner_o = last_i;
    unique case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_i;
      default: winner_o = last_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared data memory.
// M0 = CPU load/store stage, M1 = loader/DMA port. One access per cycle,
// DMEM lines driven from registered transaction state.
// Optional build macro: DMEM_ARB_BOUNDS_EN (address bounds check against DEPTH,
// out-of-range accesses are suppressed and flagged on *_err).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DMEM_DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = DMEM_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              SYS_reset,

  input  logic              M0_req,
  input  logic              M0_we,
  input  logic [ADDR_W-1:0] M0_addr,
  input  logic [DATA_W-1:0] M0_wdata,
  output logic              M0_gnt,
  output logic              M0_rvalid,
  output logic [DATA_W-1:0] M0_rdata,
  output logic              M0_err,

  input  logic              M1_req,
  input  logic              M1_we,
  input  logic [ADDR_W-1:0] M1_addr,
  input  logic [DATA_W-1:0] M1_wdata,
  output logic              M1_gnt,
  output logic              M1_rvalid,
  output logic [DATA_W-1:0] M1_rdata,
  output logic              M1_err,

  output logic [ADDR_W-1:0] DMEM_address,
  output logic [DATA_W-1:0] DMEM_data_in,
  output logic              DMEM_mem_write,
  output logic              DMEM_mem_read,
  input  logic [DATA_W-1:0] DMEM_data_out
);

`ifdef DMEM_ARB_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  owner_e              owner_q;
  owner_e              rr_last_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [1:0]          rvalid_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic [1:0]          req_vec;
  logic [1:0]          busy_mask;
  logic [1:0]          elig;
  logic                pick_valid;
  logic                pick_winner;
  logic                in_range;
  logic                addr_ok;
  logic [1:0]          gnt_vec;

  assign req_vec = {M1_req, M0_req};

  // The requester being served this cycle is masked so a held req is not
  // re-granted for the same transaction.
  assign busy_mask = (state_q == ACCESS) ? owner_mask(owner_q) : 2'b00;
  assign elig      = req_vec & ~busy_mask;

  rr_pick2 u_pick (
    .req_i    (elig),
    .last_i   (rr_last_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign addr_ok  = !BOUNDS_EN || in_range;

  // State register.
  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: both states re-arbitrate every edge, so ACCESS chains
  // back-to-back while any eligible request remains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = pick_valid ? ACCESS : IDLE;
      ACCESS:  state_d = pick_valid ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: DMEM strobes and grant only during ACCESS.
  always_comb begin
    DMEM_mem_write = 1'b0;
    DMEM_mem_read  = 1'b0;
    gnt_vec        = 2'b00;
    unique case (state_q)
      ACCESS: begin
        DMEM_mem_write = we_q & addr_ok;
        DMEM_mem_read  = ~we_q & addr_ok;
        gnt_vec        = owner_mask(owner_q);
      end
      default: ;
    endcase
  end

  assign DMEM_address = addr_q;
  assign DMEM_data_in = wdata_q;
  assign M0_gnt       = gnt_vec[0];
  assign M1_gnt       = gnt_vec[1];

  // Transaction latch and round-robin history, updated on each new grant.
  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      owner_q   <= OWN_M0;
      rr_last_q <= OWN_M1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (pick_valid) begin
      owner_q   <= owner_e'(pick_winner);
      rr_last_q <= owner_e'(pick_winner);
      if (pick_winner == OWN_M1) begin
        we_q    <= M1_we;
        addr_q  <= M1_addr;
        wdata_q <= M1_wdata;
      end else begin
        we_q    <= M0_we;
        addr_q  <= M0_addr;
        wdata_q <= M0_wdata;
      end
    end
  end

  // Read response capture at the edge that ends a read ACCESS.
  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= '0;
      if (state_q == ACCESS && !we_q) begin
        rvalid_q <= owner_mask(owner_q);
        if (owner_q == OWN_M1) begin
          rdata1_q <= addr_ok ? DMEM_data_out : '0;
        end else begin
          rdata0_q <= addr_ok ? DMEM_data_out : '0;
        end
      end
    end
  end

  assign M0_rvalid = rvalid_q[0];
  assign M1_rvalid = rvalid_q[1];
  assign M0_rdata  = rdata0_q;
  assign M1_rdata  = rdata1_q;

`ifdef DMEM_ARB_BOUNDS_EN
  logic [1:0] err_q;

  // Out-of-range flag, pulsed for the owner in the cycle after ACCESS.
  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      err_q <= '0;
    end else begin
      err_q <= '0;
      if (state_q == ACCESS && !in_range) begin
        err_q <= owner_mask(owner_q);
      end
    end
  end

  assign M0_err = err_q[0];
  assign M1_err = err_q[1];
`else
  assign M0_err = 1'b0;
  assign M1_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a read-data scoreboard.
// Bounds-check steps run only when DMEM_ARB_BOUNDS_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        SYS_reset;
  logic        M0_req, M0_we, M1_req, M1_we;
  logic [31:0] M0_addr, M0_wdata, M1_addr, M1_wdata;
  logic        M0_gnt, M0_rvalid, M0_err, M1_gnt, M1_rvalid, M1_err;
  logic [31:0] M0_rdata, M1_rdata;
  logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  logic [31:0] mem [0:255];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(256)) dut (
    .clk(clk), .SYS_reset(SYS_reset),
    .M0_req(M0_req), .M0_we(M0_we), .M0_addr(M0_addr), .M0_wdata(M0_wdata),
    .M0_gnt(M0_gnt), .M0_rvalid(M0_rvalid), .M0_rdata(M0_rdata), .M0_err(M0_err),
    .M1_req(M1_req), .M1_we(M1_we), .M1_addr(M1_addr), .M1_wdata(M1_wdata),
    .M1_gnt(M1_gnt), .M1_rvalid(M1_rvalid), .M1_rdata(M1_rdata), .M1_err(M1_err),
    .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
    .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
    .DMEM_data_out(DMEM_data_out)
  );

  // DMEM model: write on negedge, combinational read.
  always @(negedge clk) if (DMEM_mem_write) mem[DMEM_address[7:0]] <= DMEM_data_in;
  assign DMEM_data_out = mem[DMEM_address[7:0]];

  function automatic logic [31:0] init_val(int unsigned i);
    return 32'hC0DE0000 + 32'(i) * 32'd3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    M0_req = req; M0_we = we; M0_addr = a; M0_wdata = d;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    M1_req = req; M1_we = we; M1_addr = a; M1_wdata = d;
  endtask

  // Scoreboard: pop expected read data on each rvalid pulse.
  always @(negedge clk) begin
    if (M0_rvalid) begin
      if (q0.size() == 0) chk("m0_unexpected_rvalid", 32'd1, 32'd0);
      else chk("m0_sb_rdata", M0_rdata, q0.pop_front());
    end
    if (M1_rvalid) begin
      if (q1.size() == 0) chk("m1_unexpected_rvalid", 32'd1, 32'd0);
      else chk("m1_sb_rdata", M1_rdata, q1.pop_front());
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) mem[i] = init_val(i);
    SYS_reset = 1'b1;
    drv0(0, 0, '0, '0);
    drv1(0, 0, '0, '0);
    tick(); tick();

    // Reset state
    chk("rst_m0_gnt", M0_gnt, 0);       chk("rst_m1_gnt", M1_gnt, 0);
    chk("rst_m0_rvalid", M0_rvalid, 0); chk("rst_m1_rvalid", M1_rvalid, 0);
    chk("rst_m0_rdata", M0_rdata, 0);   chk("rst_m1_rdata", M1_rdata, 0);
    chk("rst_m0_err", M0_err, 0);       chk("rst_m1_err", M1_err, 0);
    chk("rst_wr", DMEM_mem_write, 0);   chk("rst_rd", DMEM_mem_read, 0);
    chk("rst_addr", DMEM_address, 0);   chk("rst_din", DMEM_data_in, 0);

    // M0 write then read back
    SYS_reset = 1'b0;
    drv0(1, 1, 32'h10, 32'hDEADBEEF);
    tick();
    chk("wr_m0_gnt", M0_gnt, 1); chk("wr_m1_gnt", M1_gnt, 0);
    chk("wr_write", DMEM_mem_write, 1); chk("wr_read", DMEM_mem_read, 0);
    chk("wr_addr", DMEM_address, 32'h10); chk("wr_din", DMEM_data_in, 32'hDEADBEEF);
    drv0(0, 0, '0, '0);
    tick();
    chk("idle_gnt", M0_gnt, 0); chk("idle_write", DMEM_mem_write, 0);
    chk("idle_addr_hold", DMEM_address, 32'h10);
    drv0(1, 0, 32'h10, '0);
    q0.push_back(32'hDEADBEEF);
    tick();
    chk("rd_m0_gnt", M0_gnt, 1); chk("rd_read", DMEM_mem_read, 1);
    chk("rd_write", DMEM_mem_write, 0);
    drv0(0, 0, '0, '0);
    tick();
    chk("rd_rvalid", M0_rvalid, 1); chk("rd_rdata", M0_rdata, 32'hDEADBEEF);
    chk("rd_gnt_after", M0_gnt, 0);
    tick();
    chk("rd_rvalid_pulse", M0_rvalid, 0); chk("rd_rdata_hold", M0_rdata, 32'hDEADBEEF);

    // Simultaneous reads from reset: M0 first, then M1
    SYS_reset = 1'b1;
    tick();
    chk("rst2_rdata", M0_rdata, 0);
    SYS_reset = 1'b0;
    drv0(1, 0, 32'h01, '0); q0.push_back(init_val(1));
    drv1(1, 0, 32'h02, '0); q1.push_back(init_val(2));
    tick();
    chk("both_m0_gnt", M0_gnt, 1); chk("both_m1_gnt0", M1_gnt, 0);
    drv0(0, 0, '0, '0);
    tick();
    chk("both_m1_gnt", M1_gnt, 1); chk("both_m0_gnt0", M0_gnt, 0);
    chk("both_m0_rvalid", M0_rvalid, 1);
    drv1(0, 0, '0, '0);
    tick();
    chk("both_m1_rvalid", M1_rvalid, 1); chk("both_m0_rvalid0", M0_rvalid, 0);
    tick();

    // Continuous requests: strict alternation, DMEM busy every cycle
    drv0(1, 0, 32'h03, '0);
    drv1(1, 0, 32'h04, '0);
    for (int k = 0; k < 3; k++) begin
      q0.push_back(init_val(3));
      q1.push_back(init_val(4));
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_m0_gnt", M0_gnt, (k % 2 == 0) ? 1 : 0);
      chk("rr_m1_gnt", M1_gnt, (k % 2 == 1) ? 1 : 0);
      chk("rr_busy", DMEM_mem_read, 1);
      if (k == 4) drv0(0, 0, '0, '0);
      if (k == 5) drv1(0, 0, '0, '0);
    end
    tick();
    chk("rr_idle_after", M0_gnt | M1_gnt, 0);
    tick();

    // M0 write leaves rr_last = M0, so M1's write beats M0's read
    drv0(1, 1, 32'h20, 32'h0);
    tick();
    chk("pre_m0_gnt", M0_gnt, 1);
    drv0(0, 0, '0, '0);
    tick();
    drv1(1, 1, 32'h20, 32'h5);
    drv0(1, 0, 32'h20, '0);
    q0.push_back(32'h5);
    tick();
    chk("raw_m1_gnt", M1_gnt, 1); chk("raw_m0_gnt0", M0_gnt, 0);
    chk("raw_write", DMEM_mem_write, 1);
    drv1(0, 0, '0, '0);
    tick();
    chk("raw_m0_gnt", M0_gnt, 1); chk("raw_read", DMEM_mem_read, 1);
    drv0(0, 0, '0, '0);
    tick();
    chk("raw_rdata", M0_rdata, 32'h5);

    // Reset during a write ACCESS; rr_last is M0 before reset
    drv0(1, 1, 32'h30, 32'h1234);
    tick();
    chk("ra_m0_gnt", M0_gnt, 1); chk("ra_write", DMEM_mem_write, 1);
    SYS_reset = 1'b1;
    drv0(0, 0, '0, '0);
    tick();
    chk("ra_write_off", DMEM_mem_write, 0); chk("ra_gnt_off", M0_gnt, 0);
    chk("ra_rvalid", M0_rvalid, 0); chk("ra_read_off", DMEM_mem_read, 0);
    SYS_reset = 1'b0;
    drv0(1, 0, 32'h06, '0); q0.push_back(init_val(6));
    drv1(1, 0, 32'h05, '0); q1.push_back(init_val(5));
    tick();
    chk("ra_first_m0", M0_gnt, 1); chk("ra_first_m1", M1_gnt, 0);
    drv0(0, 0, '0, '0);
    tick();
    chk("ra_second_m1", M1_gnt, 1);
    drv1(0, 0, '0, '0);
    tick(); tick();

`ifdef DMEM_ARB_BOUNDS_EN
    // Out-of-range write and read
    drv1(1, 1, 32'd300, 32'hBAD0BAD0);
    tick();
    chk("oob_gnt", M1_gnt, 1); chk("oob_write", DMEM_mem_write, 0);
    chk("oob_read", DMEM_mem_read, 0);
    drv1(0, 0, '0, '0);
    tick();
    chk("oob_err", M1_err, 1); chk("oob_m0_err", M0_err, 0);
    chk("oob_wr_rvalid", M1_rvalid, 0);
    tick();
    chk("oob_err_pulse", M1_err, 0);
    drv1(1, 0, 32'd44, '0); q1.push_back(init_val(44));
    tick();
    drv1(0, 0, '0, '0);
    tick();
    chk("oob_alias_rdata", M1_rdata, init_val(44));
    drv1(1, 0, 32'd300, '0); q1.push_back(32'h0);
    tick();
    chk("oob_rd_gnt", M1_gnt, 1); chk("oob_rd_read", DMEM_mem_read, 0);
    drv1(0, 0, '0, '0);
    tick();
    chk("oob_rd_err", M1_err, 1); chk("oob_rd_rvalid", M1_rvalid, 1);
    chk("oob_rd_rdata", M1_rdata, 0);
    tick();
`else
    // Without the bounds check, err stays low
    drv1(1, 1, 32'h40, 32'h77);
    tick();
    chk("nb_gnt", M1_gnt, 1); chk("nb_write", DMEM_mem_write, 1);
    drv1(0, 0, '0, '0);
    tick();
    chk("nb_m1_err", M1_err, 0); chk("nb_m0_err", M0_err, 0);
    tick();
`endif

    tick(); tick();
    chk("sb_q0_empty", 32'(q0.size()), 0);
    chk("sb_q1_empty", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
